image_diff_scanner: RTL and testbench
=====================================

// Module: image_diff_scanner
// PURPOSE
// - Raster-scans a 16x12 game grid, encodes each cell's object from game-logic flags, compares it
//   with a stored copy of what is on screen, and requests a redraw only for changed cells.
// - Sits between the snake game logic and the display command engine, which acknowledges each
//   draw with cmd_done.
// PARAMETERS
// - GRID_W  16  cells per row; x range 0..GRID_W-1
// - GRID_H  12  rows; y range 0..GRID_H-1
// PORTS
// - clk          in   1  system clock; all state changes on its rising edge
// - nrst         in   1  asynchronous active-low reset
// - snakeHead    in   1  current cell (x,y) holds the snake head
// - snakeBody    in   1  current cell holds a snake body segment
// - apple        in   1  current cell holds the apple
// - border       in   1  current cell is border wall
// - mode_pb      in   1  mode pushbutton, level
// - GameOver     in   1  game-over flag, level
// - cmd_done     in   1  display engine finished the previous command; 1-cycle pulse
// - x            out  4  scan column
// - y            out  4  scan row
// - obj_code     out  3  object code for the cell at (x,y)
// - diff         out  1  cell at (x,y) must be redrawn
// - enable_loop  out  1  scanner is in SCAN state
// - en_update    out  1  1-cycle redraw request for (x,y) with obj_code
// - init_cycle   out  1  first full-frame draw is in progress
// - sync_reset   out  1  1-cycle restart pulse
// BEHAVIOUR
// - obj_code is combinational, with priority head > body > apple > border:
//   head=3'b001, body=3'b010, apple=3'b011, border=3'b100; no flag set gives 3'b000.
// - Frame store holds 192 entries x 3 bits, indexed y*16+x.
//   diff = init_cycle | (obj_code != store[x][y]), combinational.
// - FSM states: START, SCAN, UPDATE, WAIT.
//   - START: waits for cmd_done, then goes to SCAN without moving coordinates.
//   - SCAN: enable_loop=1. diff=1 -> UPDATE. diff=0 -> advance one cell per clock.
//   - UPDATE: lasts one cycle. en_update=1; store[x][y] <= obj_code; then goes to WAIT.
//   - WAIT: holds x, y. cmd_done -> advance one cell and go to SCAN.
//   - cmd_done is ignored in SCAN and UPDATE.
// - Advancing the scan position:
//   - x increments. At x=15, x wraps to 0 and y increments.
//   - At (15,11) the position wraps to (0,0) and init_cycle clears to 0.
// - x and y never leave the 0..15 / 0..11 ranges.
// - Restart request = rising edge of mode_pb, or rising edge of GameOver (edge detectors registered).
//   On a restart request:
//   - sync_reset=1 for exactly 1 cycle.
//   - Next state is START with x=y=0 and init_cycle=1; every store entry is cleared to 3'b000.
//   - This takes priority over all other transitions, including in UPDATE and WAIT.
// - Reset values: state START, x=0, y=0, init_cycle=1, store all 0, en_update=0, enable_loop=0,
//   sync_reset=0, edge-detect registers 0. diff reads 1 immediately after reset.
// - Latency: a changed cell is detected in the same cycle it is presented. en_update follows on the
//   next clock. The position advances on the clock after cmd_done.
// STRUCTURE
// - Shared package:
//   - obj_code_t enum: EMPTY, HEAD, BODY, APPLE, BORDER.
//   - GRID_W / GRID_H constants.
//   - state_t enum.
// - One sub-module, frame_store: 192x3 register file with async clear, synchronous clear,
//   write enable, and combinational read at (x,y).
// - Top level holds the FSM, x/y counters, the encoder and the edge detectors.
// TESTING
// - Reset, hold 50 time units with no cmd_done -> x=0, y=0, init_cycle=1, enable_loop=0, en_update=0.
// - Reset, pulse cmd_done, all flags 0 at (0,0) -> SCAN, diff=1, en_update=1 one cycle later;
//   after cmd_done, x=1, y=0.
// - Full init frame:
//   - Drive border on row 0/11 and column 0/15; head (4,4), apple (6,4), else empty.
//   - Expect 192 en_update pulses, then wrap to (0,0) with init_cycle=0.
// - Second frame with an identical map -> no en_update; position advances every clock, 192 cycles.
// - Second frame with head moved to (5,4) and (4,4) empty:
//   - en_update exactly at (4,4) with obj_code 3'b000, and at (5,4) with obj_code 3'b001.
// - Restart: GameOver 0->1 while in WAIT -> sync_reset pulse for one cycle, then x=y=0,
//   init_cycle=1, state START. Holding GameOver high does not pulse again.

Source files
------------

// File: rtl/image_diff_scanner_pkg.sv
// Shared types and constants for the image diff scanner.
package image_diff_scanner_pkg;

  localparam int unsigned GRID_W = 16;
  localparam int unsigned GRID_H = 12;
  localparam int unsigned CELLS  = GRID_W * GRID_H;

  typedef enum logic [2:0] {
    ObjEmpty  = 3'b000,
    ObjHead   = 3'b001,
    ObjBody   = 3'b010,
    ObjApple  = 3'b011,
    ObjBorder = 3'b100
  } obj_code_t;

  typedef enum logic [1:0] {
    StStart,
    StScan,
    StUpdate,
    StWait
  } state_t;

  // Priority encode game-logic flags: head > body > apple > border.
  function automatic obj_code_t encode_obj(input logic head, input logic body,
                                           input logic apple, input logic border);
    if (head)        return ObjHead;
    else if (body)   return ObjBody;
    else if (apple)  return ObjApple;
    else if (border) return ObjBorder;
    else             return ObjEmpty;
  endfunction

endpackage

// File: rtl/image_diff_scanner_frame_store.sv
// Copy of what is currently on screen: one 3-bit object code per grid cell, indexed y*16+x.
module image_diff_scanner_frame_store
  import image_diff_scanner_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       we_i,
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  input  logic [2:0] wdata_i,
  output logic [2:0] rdata_o
);

  logic [2:0] mem_q [CELLS];
  logic [7:0] addr;

  // GRID_W is 16, so y*16+x is a plain concatenation.
  assign addr = {y_i, x_i};

  // Register file with async clear, sync clear (wins over write) and single write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < CELLS; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int unsigned i = 0; i < CELLS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[addr] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr];

endmodule

// File: rtl/image_diff_scanner.sv
// Raster-scans the game grid and requests a redraw only for cells that differ from the screen.
module image_diff_scanner
  import image_diff_scanner_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       snakeHead,
  input  logic       snakeBody,
  input  logic       apple,
  input  logic       border,
  input  logic       mode_pb,
  input  logic       GameOver,
  input  logic       cmd_done,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [2:0] obj_code,
  output logic       diff,
  output logic       enable_loop,
  output logic       en_update,
  output logic       init_cycle,
  output logic       sync_reset
);

  localparam logic [3:0] XMax = 4'(GRID_W - 1);
  localparam logic [3:0] YMax = 4'(GRID_H - 1);

  state_t     state_q, state_d;
  logic [3:0] x_q, x_d, y_q, y_d;
  logic       init_q, init_d;
  logic       mode_q, over_q, sync_q;
  logic       restart, advance, store_we;
  logic [2:0] store_rdata;
  obj_code_t  obj_enc;

  assign restart = (mode_pb & ~mode_q) | (GameOver & ~over_q);

  // Combinational object encoding of the cell currently presented.
  always_comb begin
    obj_enc = encode_obj(snakeHead, snakeBody, apple, border);
  end

  assign obj_code    = obj_enc;
  assign diff        = init_q | (obj_code != store_rdata);
  assign x           = x_q;
  assign y           = y_q;
  assign init_cycle  = init_q;
  assign sync_reset  = sync_q;
  assign enable_loop = (state_q == StScan);
  assign en_update   = (state_q == StUpdate);
  // A restart clears the store, so drop any write landing in the same cycle.
  assign store_we    = (state_q == StUpdate) & ~restart;

  // Next-state, scan position and init flag; restart overrides everything.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    init_d  = init_q;
    advance = 1'b0;

    unique case (state_q)
      StStart:  if (cmd_done) state_d = StScan;
      StScan: begin
        if (diff) state_d = StUpdate;
        else      advance = 1'b1;
      end
      StUpdate: state_d = StWait;
      StWait: begin
        if (cmd_done) begin
          advance = 1'b1;
          state_d = StScan;
        end
      end
      default:  state_d = StStart;
    endcase

    if (advance) begin
      if (x_q == XMax) begin
        x_d = '0;
        if (y_q == YMax) begin
          y_d    = '0;
          init_d = 1'b0;
        end else begin
          y_d = y_q + 4'd1;
        end
      end else begin
        x_d = x_q + 4'd1;
      end
    end

    if (restart) begin
      state_d = StStart;
      x_d     = '0;
      y_d     = '0;
      init_d  = 1'b1;
    end
  end

  // State, position, edge-detect and restart-pulse registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StStart;
      x_q     <= '0;
      y_q     <= '0;
      init_q  <= 1'b1;
      mode_q  <= 1'b0;
      over_q  <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      init_q  <= init_d;
      mode_q  <= mode_pb;
      over_q  <= GameOver;
      sync_q  <= restart;
    end
  end

  image_diff_scanner_frame_store u_frame_store (
    .clk_i   (clk),
    .rst_ni  (nrst),
    .clr_i   (restart),
    .we_i    (store_we),
    .x_i     (x_q),
    .y_i     (y_q),
    .wdata_i (obj_code),
    .rdata_o (store_rdata)
  );

endmodule

// File: tb/tb_image_diff_scanner.sv
// Directed bench for image_diff_scanner: a map of game flags drives the DUT by (x,y).
module tb_image_diff_scanner;

  logic       tb_clk = 1'b0;
  logic       nrst;
  logic       snakeHead, snakeBody, apple, border;
  logic       mode_pb, GameOver, cmd_done;
  logic [3:0] x, y;
  logic [2:0] obj_code;
  logic       diff, enable_loop, en_update, init_cycle, sync_reset;

  int checks   = 0;
  int failures = 0;

  // Per-cell flags {head, body, apple, border}, indexed {y, x}.
  logic [3:0]  flags_map [256];
  logic [10:0] log_q [$];

  assign snakeHead = flags_map[{y, x}][3];
  assign snakeBody = flags_map[{y, x}][2];
  assign apple     = flags_map[{y, x}][1];
  assign border    = flags_map[{y, x}][0];

  always #5 tb_clk = ~tb_clk;

  image_diff_scanner dut (
    .clk         (tb_clk),
    .nrst        (nrst),
    .snakeHead   (snakeHead),
    .snakeBody   (snakeBody),
    .apple       (apple),
    .border      (border),
    .mode_pb     (mode_pb),
    .GameOver    (GameOver),
    .cmd_done    (cmd_done),
    .x           (x),
    .y           (y),
    .obj_code    (obj_code),
    .diff        (diff),
    .enable_loop (enable_loop),
    .en_update   (en_update),
    .init_cycle  (init_cycle),
    .sync_reset  (sync_reset)
  );

  function automatic logic [2:0] exp_code(input logic [3:0] f);
    if (f[3])      return 3'b001;
    else if (f[2]) return 3'b010;
    else if (f[1]) return 3'b011;
    else if (f[0]) return 3'b100;
    else           return 3'b000;
  endfunction

  task automatic clear_map();
    for (int i = 0; i < 256; i++) flags_map[i] = 4'b0000;
  endtask

  task automatic game_map(input int hx);
    clear_map();
    for (int yy = 0; yy < 12; yy++)
      for (int xx = 0; xx < 16; xx++)
        if (yy == 0 || yy == 11 || xx == 0 || xx == 15) flags_map[yy*16+xx] = 4'b0001;
    flags_map[4*16+hx] = 4'b1000;
    flags_map[4*16+6]  = 4'b0010;
  endtask

  task automatic do_reset();
    cmd_done = 1'b0;
    mode_pb  = 1'b0;
    GameOver = 1'b0;
    nrst     = 1'b0;
    #50;
    @(negedge tb_clk);
    nrst = 1'b1;
  endtask

  task automatic pulse_cmd_done();
    @(negedge tb_clk);
    cmd_done = 1'b1;
    @(negedge tb_clk);
    cmd_done = 1'b0;
  endtask

  // Acts as the display engine for one frame; stops when the scan returns to (0,0).
  task automatic scan_frame(output int updates, output int cycles, output bit timed_out);
    bit left;
    updates   = 0;
    cycles    = 0;
    timed_out = 1'b1;
    left      = 1'b0;
    log_q.delete();
    for (int i = 0; i < 3000; i++) begin
      @(negedge tb_clk);
      cycles++;
      if (en_update) begin
        updates++;
        log_q.push_back({y, x, obj_code});
        @(negedge tb_clk);
        cmd_done = 1'b1;
        @(negedge tb_clk);
        cmd_done = 1'b0;
        cycles += 2;
      end
      if (x != 4'd0 || y != 4'd0) left = 1'b1;
      else if (left) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; cmd_done = 1'b0; mode_pb = 1'b0; GameOver = 1'b0;
    clear_map();
    #50;
    checks++; if (x !== 4'd0) begin failures++; $display("FAIL rst_x got %0d exp 0", x); end
    checks++; if (y !== 4'd0) begin failures++; $display("FAIL rst_y got %0d exp 0", y); end
    checks++; if (init_cycle !== 1'b1) begin failures++; $display("FAIL rst_init got %b exp 1", init_cycle); end
    checks++; if (enable_loop !== 1'b0) begin failures++; $display("FAIL rst_loop got %b exp 0", enable_loop); end
    checks++; if (en_update !== 1'b0) begin failures++; $display("FAIL rst_upd got %b exp 0", en_update); end
    checks++; if (diff !== 1'b1) begin failures++; $display("FAIL rst_diff got %b exp 1", diff); end
    @(negedge tb_clk);
    nrst = 1'b1;
    repeat (3) @(negedge tb_clk);
    checks++; if (enable_loop !== 1'b0) begin failures++; $display("FAIL idle_loop got %b exp 0", enable_loop); end
    checks++; if (x !== 4'd0) begin failures++; $display("FAIL idle_x got %0d exp 0", x); end
    checks++; if (sync_reset !== 1'b0) begin failures++; $display("FAIL idle_sync got %b exp 0", sync_reset); end
  endtask

  task automatic test_encoder();
    logic [3:0] f_tab [6];
    logic [2:0] e_tab [6];
    f_tab = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1001};
    e_tab = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000, 3'b001};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      flags_map[0] = f_tab[i];
      #1;
      checks++;
      if (obj_code !== e_tab[i]) begin
        failures++;
        $display("FAIL enc_%0d flags=%b got %b exp %b", i, f_tab[i], obj_code, e_tab[i]);
      end
    end
    clear_map();
  endtask

  task automatic test_first_cell();
    do_reset();
    clear_map();
    pulse_cmd_done();
    checks++; if (enable_loop !== 1'b1) begin failures++; $display("FAIL fc_scan got %b exp 1", enable_loop); end
    checks++; if (diff !== 1'b1) begin failures++; $display("FAIL fc_diff got %b exp 1", diff); end
    checks++; if (en_update !== 1'b0) begin failures++; $display("FAIL fc_upd0 got %b exp 0", en_update); end
    @(negedge tb_clk);
    checks++; if (en_update !== 1'b1) begin failures++; $display("FAIL fc_upd1 got %b exp 1", en_update); end
    @(negedge tb_clk);
    checks++; if (en_update !== 1'b0) begin failures++; $display("FAIL fc_wait_upd got %b exp 0", en_update); end
    checks++; if (x !== 4'd0) begin failures++; $display("FAIL fc_wait_x got %0d exp 0", x); end
    pulse_cmd_done();
    checks++; if (x !== 4'd1 || y !== 4'd0) begin
      failures++; $display("FAIL fc_adv got (%0d,%0d) exp (1,0)", x, y);
    end
  endtask

  task automatic test_frames();
    int upd, cyc, mm;
    bit to;
    do_reset();
    game_map(4);
    pulse_cmd_done();
    scan_frame(upd, cyc, to);
    checks++; if (to) begin failures++; $display("FAIL f1_timeout got 1 exp 0"); end
    checks++; if (upd != 192) begin failures++; $display("FAIL f1_updates got %0d exp 192", upd); end
    checks++; if (init_cycle !== 1'b0) begin failures++; $display("FAIL f1_init got %b exp 0", init_cycle); end
    checks++; if (x !== 4'd0 || y !== 4'd0) begin
      failures++; $display("FAIL f1_wrap got (%0d,%0d) exp (0,0)", x, y);
    end
    mm = 0;
    if (log_q.size() == 192) begin
      for (int i = 0; i < 192; i++)
        if (log_q[i] !== {i[7:0], exp_code(flags_map[i])}) mm++;
    end else begin
      mm = 999;
    end
    checks++; if (mm != 0) begin failures++; $display("FAIL f1_log got %0d bad exp 0", mm); end
    checks++; if (log_q.size() < 71 || log_q[68] !== {4'd4, 4'd4, 3'b001}) begin
      failures++; $display("FAIL f1_head got %h exp %h", (log_q.size() > 68) ? log_q[68] : 11'h0,
                           {4'd4, 4'd4, 3'b001});
    end
    checks++; if (log_q.size() < 71 || log_q[70] !== {4'd4, 4'd6, 3'b011}) begin
      failures++; $display("FAIL f1_apple got %h exp %h", (log_q.size() > 70) ? log_q[70] : 11'h0,
                           {4'd4, 4'd6, 3'b011});
    end

    // Identical map: nothing to redraw, one cell per clock.
    scan_frame(upd, cyc, to);
    checks++; if (to) begin failures++; $display("FAIL f2_timeout got 1 exp 0"); end
    checks++; if (upd != 0) begin failures++; $display("FAIL f2_updates got %0d exp 0", upd); end
    checks++; if (cyc != 192) begin failures++; $display("FAIL f2_cycles got %0d exp 192", cyc); end

    // Head moves from (4,4) to (5,4).
    game_map(5);
    scan_frame(upd, cyc, to);
    checks++; if (to) begin failures++; $display("FAIL f3_timeout got 1 exp 0"); end
    checks++; if (upd != 2) begin failures++; $display("FAIL f3_updates got %0d exp 2", upd); end
    checks++; if (log_q.size() < 1 || log_q[0] !== {4'd4, 4'd4, 3'b000}) begin
      failures++; $display("FAIL f3_old got %h exp %h", (log_q.size() > 0) ? log_q[0] : 11'h0,
                           {4'd4, 4'd4, 3'b000});
    end
    checks++; if (log_q.size() < 2 || log_q[1] !== {4'd4, 4'd5, 3'b001}) begin
      failures++; $display("FAIL f3_new got %h exp %h", (log_q.size() > 1) ? log_q[1] : 11'h0,
                           {4'd4, 4'd5, 3'b001});
    end
  endtask

  task automatic test_restart();
    int pulses;
    do_reset();
    clear_map();
    pulse_cmd_done();
    @(negedge tb_clk);
    pulse_cmd_done();
    @(negedge tb_clk);
    checks++; if (en_update !== 1'b1 || x !== 4'd1) begin
      failures++; $display("FAIL rs_upd got upd=%b x=%0d exp upd=1 x=1", en_update, x);
    end
    @(negedge tb_clk);
    GameOver = 1'b1;
    @(posedge tb_clk);
    #1;
    checks++; if (sync_reset !== 1'b1) begin failures++; $display("FAIL rs_sync got %b exp 1", sync_reset); end
    checks++; if (x !== 4'd0 || y !== 4'd0) begin
      failures++; $display("FAIL rs_pos got (%0d,%0d) exp (0,0)", x, y);
    end
    checks++; if (init_cycle !== 1'b1) begin failures++; $display("FAIL rs_init got %b exp 1", init_cycle); end
    checks++; if (enable_loop !== 1'b0 || en_update !== 1'b0) begin
      failures++; $display("FAIL rs_state got loop=%b upd=%b exp 0 0", enable_loop, en_update);
    end
    pulses = 0;
    repeat (6) begin
      @(posedge tb_clk);
      #1;
      if (sync_reset) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL rs_hold got %0d exp 0", pulses); end
    checks++; if (enable_loop !== 1'b0 || x !== 4'd0) begin
      failures++; $display("FAIL rs_start got loop=%b x=%0d exp 0 0", enable_loop, x);
    end
    @(negedge tb_clk);
    mode_pb = 1'b1;
    @(posedge tb_clk);
    #1;
    checks++; if (sync_reset !== 1'b1) begin failures++; $display("FAIL rs_mode got %b exp 1", sync_reset); end
    @(posedge tb_clk);
    #1;
    checks++; if (sync_reset !== 1'b0) begin failures++; $display("FAIL rs_mode_end got %b exp 0", sync_reset); end
  endtask

  initial begin
    test_reset();
    test_encoder();
    test_first_cell();
    test_frames();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
